ook_symbol_sched: RTL and testbench

OOK_SYMBOL_SCHED -- requirements
Module: ook_symbol_sched

---
 rtl/ook_symbol_sched.sv | 215 +++++++++++++++++++++
 tb/tb_ook_symbol_sched.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ook_symbol_sched.sv
// ook_symbol_sched: on-off-keying symbol scheduler.
// Bytes are queued in a small FIFO. Each byte is shifted out MSB first on ook_data.
// Every bit is held for sym_div+1 clocks, using the sym_div value latched when the byte loads.
// When the OOK_PREAMBLE_EN macro is defined, a burst that starts from idle is preceded by an
// 8'hAA preamble.
module ook_symbol_sched #(
  parameter int unsigned SYM_DIV_W  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SYM_DIV_W-1:0]        sym_div,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        ook_data,
  output logic                        busy,
  output logic                        byte_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] FullLvl = LvlW'(FIFO_DEPTH);

`ifdef OOK_PREAMBLE_EN
  localparam logic [7:0] Preamble = 8'hAA;
  typedef enum logic [1:0] {StIdle, StPreamble, StSend} state_e;
`else
  typedef enum logic [0:0] {StIdle, StSend} state_e;
`endif

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [LvlW-1:0] r_count;
  logic            w_push;
  logic            w_pop;
  logic            w_fifo_nonempty;
  logic [7:0]      w_head;

  // Readiness comes from the registered count only, so a same-edge pop never frees a slot.
  assign in_ready        = (r_count != FullLvl);
  assign w_push          = in_valid && in_ready;
  assign w_fifo_nonempty = (r_count != '0);
  assign w_head          = r_mem[r_rd_ptr];
  assign fifo_level      = r_count;

  // Byte storage. Occupancy is tracked by r_count, so the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LvlW'(1);
        2'b01:   r_count <= r_count - LvlW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Symbol FSM
  // ---------------------------------------------------------------------------
  state_e               r_state;
  state_e               w_state_d;
  logic [7:0]           r_shift;
  logic [7:0]           w_shift_d;
  logic [SYM_DIV_W-1:0] r_sym_cnt;
  logic [SYM_DIV_W-1:0] w_sym_cnt_d;
  logic [SYM_DIV_W-1:0] r_div;
  logic [SYM_DIV_W-1:0] w_div_d;
  logic [2:0]           r_bit_cnt;
  logic [2:0]           w_bit_cnt_d;
  logic                 r_ook;
  logic                 w_ook_d;
  logic                 r_byte_done;
  logic                 w_byte_done_d;
  logic                 w_sym_end;
`ifdef OOK_PREAMBLE_EN
  logic [7:0]           r_hold;
  logic [7:0]           w_hold_d;
`endif

  assign w_sym_end = (r_sym_cnt == '0);

  // Next-state logic: per-bit countdown, bit shifting and byte loading.
  always_comb begin
    w_state_d     = r_state;
    w_shift_d     = r_shift;
    w_sym_cnt_d   = r_sym_cnt;
    w_div_d       = r_div;
    w_bit_cnt_d   = r_bit_cnt;
    w_byte_done_d = 1'b0;
    w_pop         = 1'b0;
`ifdef OOK_PREAMBLE_EN
    w_hold_d      = r_hold;
`endif
    case (r_state)
      StIdle: begin
        if (w_fifo_nonempty) begin
          w_pop       = 1'b1;
          w_div_d     = sym_div;
          w_sym_cnt_d = sym_div;
          w_bit_cnt_d = '0;
`ifdef OOK_PREAMBLE_EN
          // The popped byte waits in r_hold while the preamble goes out.
          w_hold_d    = w_head;
          w_shift_d   = Preamble;
          w_state_d   = StPreamble;
`else
          w_shift_d   = w_head;
          w_state_d   = StSend;
`endif
        end
      end
`ifdef OOK_PREAMBLE_EN
      StPreamble: begin
        if (!w_sym_end) begin
          w_sym_cnt_d = r_sym_cnt - SYM_DIV_W'(1);
        end else if (r_bit_cnt == 3'd7) begin
          // The payload keeps the symbol period latched for the preamble.
          w_shift_d   = r_hold;
          w_sym_cnt_d = r_div;
          w_bit_cnt_d = '0;
          w_state_d   = StSend;
        end else begin
          w_shift_d   = {r_shift[6:0], 1'b0};
          w_sym_cnt_d = r_div;
          w_bit_cnt_d = r_bit_cnt + 3'd1;
        end
      end
`endif
      StSend: begin
        if (!w_sym_end) begin
          w_sym_cnt_d = r_sym_cnt - SYM_DIV_W'(1);
        end else if (r_bit_cnt == 3'd7) begin
          w_byte_done_d = 1'b1;
          if (w_fifo_nonempty) begin
            // Back-to-back: load the next byte on this edge with a fresh sym_div.
            w_pop       = 1'b1;
            w_div_d     = sym_div;
            w_sym_cnt_d = sym_div;
            w_bit_cnt_d = '0;
            w_shift_d   = w_head;
          end else begin
            w_shift_d   = '0;
            w_sym_cnt_d = '0;
            w_bit_cnt_d = '0;
            w_state_d   = StIdle;
          end
        end else begin
          w_shift_d   = {r_shift[6:0], 1'b0};
          w_sym_cnt_d = r_div;
          w_bit_cnt_d = r_bit_cnt + 3'd1;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
    // The keying bit is registered so that it follows the shift register MSB with no extra lag.
    w_ook_d = (w_state_d != StIdle) ? w_shift_d[7] : 1'b0;
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_shift     <= '0;
      r_sym_cnt   <= '0;
      r_div       <= '0;
      r_bit_cnt   <= '0;
      r_ook       <= 1'b0;
      r_byte_done <= 1'b0;
`ifdef OOK_PREAMBLE_EN
      r_hold      <= '0;
`endif
    end else begin
      r_state     <= w_state_d;
      r_shift     <= w_shift_d;
      r_sym_cnt   <= w_sym_cnt_d;
      r_div       <= w_div_d;
      r_bit_cnt   <= w_bit_cnt_d;
      r_ook       <= w_ook_d;
      r_byte_done <= w_byte_done_d;
`ifdef OOK_PREAMBLE_EN
      r_hold      <= w_hold_d;
`endif
    end
  end

  assign ook_data  = r_ook;
  assign busy      = (r_state != StIdle);
  assign byte_done = r_byte_done;

endmodule

// File: tb/tb_ook_symbol_sched.sv
// Bench for ook_symbol_sched: directed scenarios plus randomized traffic, each cycle checked
// against a time-window model of the byte schedule.
`timescale 1ns/1ps
module tb_ook_symbol_sched;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] sym_div = '0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          ook_data;
  logic          busy;
  logic          byte_done;
  logic [LW-1:0] fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ook_symbol_sched #(.SYM_DIV_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .sym_div    (sym_div),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ook_data   (ook_data),
    .busy       (busy),
    .byte_done  (byte_done),
    .fifo_level (fifo_level)
  );

  // Reference model. Each loaded byte occupies the window [m_start, m_end) of clock edges.
  // Its bits, including any preamble, are spread evenly across that window.
  logic [7:0]    q[$];
  bit            m_have = 1'b0;
  int            m_start = 0;
  int            m_end = 0;
  int            m_d = 0;
  logic [15:0]   m_bits = '0;
  int            t_now = 0;
  logic [LW+3:0] want;
  logic [LW+3:0] got;

  // Drive one clock of stimulus, advance the model to the same edge, then sample the DUT.
  task automatic step(input logic v, input logic [7:0] d, input logic [DW-1:0] div,
                      input logic r, output bit acc);
    bit   rdy;
    bit   cont;
    logic e_ook;
    logic e_busy;
    logic e_done;
    int   idx;
    rst      = r;
    in_valid = v;
    in_data  = d;
    sym_div  = div;
    t_now++;
    acc    = 1'b0;
    e_done = 1'b0;
    if (r) begin
      q.delete();
      m_have = 1'b0;
    end else begin
      cont   = m_have && (t_now == m_end);
      e_done = cont;
      rdy    = (q.size() != DEPTH);
      if (q.size() != 0 && (!m_have || t_now >= m_end)) begin
        m_start = t_now;
        m_d     = int'(div);
        m_have  = 1'b1;
`ifdef OOK_PREAMBLE_EN
        if (cont) begin
          m_bits = {q.pop_front(), 8'h00};
          m_end  = t_now + 8 * (m_d + 1);
        end else begin
          m_bits = {8'hAA, q.pop_front()};
          m_end  = t_now + 16 * (m_d + 1);
        end
`else
        m_bits = {q.pop_front(), 8'h00};
        m_end  = t_now + 8 * (m_d + 1);
`endif
      end
      if (v && rdy) begin
        q.push_back(d);
        acc = 1'b1;
      end
    end
    e_busy = m_have && (t_now < m_end);
    idx    = 15 - (t_now - m_start) / (m_d + 1);
    e_ook  = e_busy ? m_bits[idx[3:0]] : 1'b0;
    want   = {e_ook, e_busy, e_done, q.size() != DEPTH, LW'(q.size())};
    @(posedge clk);
    #1;
    got = {ook_data, busy, byte_done, in_ready, fifo_level};
  endtask

  task automatic test_reset();
    bit acc;
    step(1'b0, 8'h00, 16'd3, 1'b1, acc);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_state got=%b want=%b", got, want);
    end
    checks++;
    if (in_ready !== 1'b1 || fifo_level !== '0) begin
      errors++;
      $display("FAIL reset_ready got=%b/%0d want=1/0", in_ready, fifo_level);
    end
    step(1'b0, 8'h00, 16'd3, 1'b0, acc);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_idle got=%b want=%b", got, want);
    end
  endtask

  task automatic test_single();
    bit          acc;
    logic [31:0] pat = '0;
    int          dn = 0;
    step(1'b1, 8'hA5, 16'd3, 1'b0, acc);
    for (int k = 0; k < 72; k++) begin
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL single t=%0d got=%b want=%b", t_now, got, want);
      end
      step(1'b0, 8'h00, 16'd3, 1'b0, acc);
      if (k < 32) pat = {pat[30:0], ook_data};
      if (byte_done === 1'b1) dn++;
    end
`ifndef OOK_PREAMBLE_EN
    checks++;
    if (pat !== 32'hF0F00F0F) begin
      errors++;
      $display("FAIL single_pattern got=%h want=f0f00f0f", pat);
    end
`endif
    checks++;
    if (dn != 1) begin
      errors++;
      $display("FAIL single_done_count got=%0d want=1", dn);
    end
  endtask

  task automatic test_back_to_back();
    bit          acc;
    logic [15:0] pat = '0;
    int          dn = 0;
    int          d0 = -1;
    int          d1 = -1;
    step(1'b1, 8'hF0, 16'd0, 1'b0, acc);
    for (int k = 0; k < 40; k++) begin
      step(k == 0, 8'h0F, 16'd0, 1'b0, acc);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL b2b t=%0d got=%b want=%b", t_now, got, want);
      end
      if (k < 16) pat = {pat[14:0], ook_data};
      if (byte_done === 1'b1) begin
        if (dn == 0) d0 = k;
        else d1 = k;
        dn++;
      end
    end
`ifndef OOK_PREAMBLE_EN
    checks++;
    if (pat !== 16'b1111000000001111) begin
      errors++;
      $display("FAIL b2b_pattern got=%b want=1111000000001111", pat);
    end
`endif
    checks++;
    if (dn != 2 || d1 - d0 != 8) begin
      errors++;
      $display("FAIL b2b_done got=%0d pulses gap %0d want=2 pulses gap 8", dn, d1 - d0);
    end
  endtask

  task automatic test_fifo_full();
    bit         acc;
    logic [7:0] bytes[6];
    int         n = 0;
    bit         saw_full = 1'b0;
    for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
    for (int k = 0; k < 260; k++) begin
      step(n < 6, bytes[(n < 6) ? n : 0], 16'd3, 1'b0, acc);
      if (acc) n++;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL fifo_full t=%0d got=%b want=%b", t_now, got, want);
      end
      if (in_ready === 1'b0 && fifo_level === LW'(DEPTH)) saw_full = 1'b1;
    end
    checks++;
    if (!saw_full) begin
      errors++;
      $display("FAIL fifo_full_seen got=0 want=1");
    end
  endtask

  task automatic test_div_change();
    bit         acc;
    logic [7:0] b0 = 8'($urandom);
    logic [7:0] b1 = 8'($urandom);
    int         d0 = -1;
    int         d1 = -1;
    for (int k = 0; k < 130; k++) begin
      step(k < 2, (k == 0) ? b0 : b1, (k < 11) ? 16'd2 : 16'd7, 1'b0, acc);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL div_change t=%0d got=%b want=%b", t_now, got, want);
      end
      if (byte_done === 1'b1) begin
        if (d0 < 0) d0 = k;
        else d1 = k;
      end
    end
`ifndef OOK_PREAMBLE_EN
    checks++;
    if (d0 != 25 || d1 != 89) begin
      errors++;
      $display("FAIL div_change_done got=%0d,%0d want=25,89", d0, d1);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit acc;
    int dn = 0;
    for (int k = 0; k < 11; k++) begin
      step(k < 3, 8'($urandom), 16'd1, 1'b0, acc);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid_pre t=%0d got=%b want=%b", t_now, got, want);
      end
    end
    step(1'b0, 8'h00, 16'd1, 1'b1, acc);
    checks++;
    if ({ook_data, busy, byte_done, fifo_level} !== '0) begin
      errors++;
      $display("FAIL reset_mid_abort got=%b%b%b/%0d want=000/0", ook_data, busy, byte_done,
               fifo_level);
    end
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 8'h00, 16'd1, 1'b0, acc);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid_post t=%0d got=%b want=%b", t_now, got, want);
      end
      if (byte_done === 1'b1) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL reset_mid_done got=%0d want=0", dn);
    end
  endtask

  task automatic test_random();
    bit            acc;
    logic [DW-1:0] div;
    for (int it = 0; it < 4; it++) begin
      div = DW'($urandom_range(0, 3));
      for (int k = 0; k < 300; k++) begin
        if ($urandom_range(0, 29) == 0) div = DW'($urandom_range(0, 3));
        step(($urandom_range(0, 3) == 0) && (k < 240), 8'($urandom), div,
             $urandom_range(0, 199) == 0, acc);
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL random it=%0d t=%0d got=%b want=%b", it, t_now, got, want);
        end
      end
    end
  endtask

`ifdef OOK_PREAMBLE_EN
  task automatic test_preamble();
    bit          acc;
    logic [31:0] pat = '0;
    int          dn = 0;
    step(1'b1, 8'hFF, 16'd1, 1'b0, acc);
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 8'h00, 16'd1, 1'b0, acc);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL preamble t=%0d got=%b want=%b", t_now, got, want);
      end
      if (k < 32) pat = {pat[30:0], ook_data};
      if (byte_done === 1'b1) dn++;
    end
    checks++;
    if (pat !== 32'hCCCCFFFF || dn != 1) begin
      errors++;
      $display("FAIL preamble_pattern got=%h/%0d want=ccccffff/1", pat, dn);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_div_change();
    test_reset_mid();
`ifdef OOK_PREAMBLE_EN
    test_preamble();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
